// File: rtl/cfa_window_5x5.sv
// rtl/cfa_window_5x5.sv - 5x5 Bayer CFA window generator feeding the equ1 gradient core.
// Four line buffers supply the older rows; a 5x5 register array forms the window taps.
module cfa_window_5x5 #(
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8,
  parameter int PIX_W      = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sof,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_in,
  output logic             start,
  output logic [PIX_W-1:0] e1t1, e1t2, e1t3, e1t4, e1t5,
  output logic [PIX_W-1:0] e2t1, e2t2, e2t3, e2t4, e2t5,
  output logic [PIX_W-1:0] e3t1, e3t2, e3t3, e3t4, e3t5,
  output logic [PIX_W-1:0] e4t1, e4t2, e4t3, e4t4, e4t5,
  output logic [PIX_W-1:0] e5t1, e5t2, e5t3, e5t4, e5t5,
  output logic             frame_done
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic             active;
  logic [PIX_W-1:0] lb  [4][IMG_WIDTH];
  logic [PIX_W-1:0] win [5][5];

  logic             accept;
  logic [CW-1:0]    cur_col;
  logic [RW-1:0]    cur_row;
  logic             last_col;
  logic             last_row;
  logic [PIX_W-1:0] col_vec [5];

  // Pixels are ignored until a sof has opened a frame after reset.
  assign accept   = pix_valid && (sof || active);
  assign cur_col  = sof ? '0 : col;
  assign cur_row  = sof ? '0 : row;
  assign last_col = (cur_col == LAST_COL);
  assign last_row = (cur_row == LAST_ROW);

  assign col_vec[0] = lb[3][cur_col];
  assign col_vec[1] = lb[2][cur_col];
  assign col_vec[2] = lb[1][cur_col];
  assign col_vec[3] = lb[0][cur_col];
  assign col_vec[4] = pix_in;

  // Line buffers hold no reset: only rows of the current frame ever reach a valid window.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb[0][cur_col] <= pix_in;
      lb[1][cur_col] <= lb[0][cur_col];
      lb[2][cur_col] <= lb[1][cur_col];
      lb[3][cur_col] <= lb[2][cur_col];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      active     <= 1'b0;
      start      <= 1'b0;
      frame_done <= 1'b0;
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++)
          win[r][c] <= '0;
    end else begin
      start      <= 1'b0;
      frame_done <= 1'b0;
      if (accept) begin
        active <= 1'b1;
        for (int r = 0; r < 5; r++) begin
          for (int c = 0; c < 4; c++)
            win[r][c] <= win[r][c+1];
          win[r][4] <= col_vec[r];
        end
        start      <= (cur_row >= RW'(4)) && (cur_col >= CW'(4));
        frame_done <= last_col && last_row;
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : cur_row + 1'b1;
        end else begin
          col <= cur_col + 1'b1;
          row <= cur_row;
        end
      end
    end
  end

  assign e1t1 = win[0][0]; assign e1t2 = win[0][1]; assign e1t3 = win[0][2];
  assign e1t4 = win[0][3]; assign e1t5 = win[0][4];
  assign e2t1 = win[1][0]; assign e2t2 = win[1][1]; assign e2t3 = win[1][2];
  assign e2t4 = win[1][3]; assign e2t5 = win[1][4];
  assign e3t1 = win[2][0]; assign e3t2 = win[2][1]; assign e3t3 = win[2][2];
  assign e3t4 = win[2][3]; assign e3t5 = win[2][4];
  assign e4t1 = win[3][0]; assign e4t2 = win[3][1]; assign e4t3 = win[3][2];
  assign e4t4 = win[3][3]; assign e4t5 = win[3][4];
  assign e5t1 = win[4][0]; assign e5t2 = win[4][1]; assign e5t3 = win[4][2];
  assign e5t4 = win[4][3]; assign e5t5 = win[4][4];

endmodule

// File: doc/cfa_window_5x5.md
Name: cfa_window_5x5

Overview:
- Window generator that drives the equ1 gradient core.
- Accepts a raster-order stream of 12-bit Bayer CFA pixels, buffers four previous image lines and presents every fully-interior 5x5 neighbourhood on the e1t1..e5t5 bus with a one-cycle start strobe.
- Sits between the sensor/file pixel source and equ1. Output names and widths match equ1's inputs one-to-one.

Parameters:
- IMG_WIDTH, 8, pixels per line (>= 5).
- IMG_HEIGHT, 8, lines per frame (>= 5).
- PIX_W, 12, pixel width in bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- sof  input  1  start of frame, qualified by pix_valid; marks pixel (0,0).
- pix_valid  input  1  pix_in carries a valid pixel this cycle.
- pix_in  input  PIX_W  raster-order pixel.
- start  output  1  one-cycle strobe: e1t1..e5t5 hold a new valid window.
- e1t1..e5t5  output  PIX_W each (25 ports)  window taps. eRtC = row R (1 = oldest line), column C (1 = leftmost/oldest).
- frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Reset (async, rst=1): all 25 taps = 0, start = 0, frame_done = 0, col/row counters = 0, window shift registers cleared. Line-buffer RAM contents are don't-care.
- Counters:
  - col advances 0..IMG_WIDTH-1 on each accepted pixel.
  - At wrap, col returns to 0 and row advances.
  - After (IMG_WIDTH-1, IMG_HEIGHT-1) both return to 0 and frame_done pulses on the next cycle.
- Line buffers:
  - 4 lines x IMG_WIDTH x PIX_W. Each is read and written at index col on an accepted pixel; the write is the cascade of the line above.
  - Column tap vector = {lb3[col], lb2[col], lb1[col], lb0[col], pix_in}, oldest first.
- Window:
  - 5x5 register array shifts left by one column on each accepted pixel; the new column enters at t5.
  - Window is valid when row >= 4 and col >= 4 (no border padding).
  - Windows per frame = (IMG_WIDTH-4)*(IMG_HEIGHT-4).
- Latency:
  - Pixel (r,c) accepted in cycle N gives taps updated in cycle N+1 and start=1 for exactly cycle N+1.
  - e5t5 = pixel (r,c); e3t3 = (r-2,c-2); e1t1 = (r-4,c-4).
- Stalls: pix_valid=0 means no state change. Taps hold their last values, start=0.
- Line wrap: the shift register still shifts across line boundaries, but start is suppressed for col < 4, so stale columns are never flagged.
- sof with pix_valid:
  - Forces this pixel to (0,0). Counters restart regardless of the current position, and the pixel is accepted normally.
  - A partial previous frame is abandoned without a frame_done.
  - sof without pix_valid is ignored.
- Mid-frame reset: everything returns to reset values immediately, and the next frame requires sof.
- No backpressure: the downstream consumer must accept one window per cycle.

Test Plan:
- Basic frame, IMG_WIDTH=IMG_HEIGHT=8, pix_in = 16*r+c, continuous valid:
  - First start is the cycle after pixel (4,4), with e1t1=0, e3t3=34, e5t5=68, e1t5=4, e5t1=64.
  - Exactly 16 start pulses per frame.
  - frame_done pulses once, one cycle after pixel (7,7).
- Same frame with pix_valid low for 3 cycles after every 2nd pixel: identical sequence of tap values on start cycles; taps hold and start=0 during gaps.
- Line-wrap check: no start for pixels (5,0)..(5,3). The window after (5,4) has e1t1=16, e5t5=84.
- sof asserted at pixel (3,2) of a frame: counters restart, no frame_done for the abandoned frame, and the next 64 pixels give 16 correct windows.
- Async rst asserted mid-cycle at row 5: taps and start drop to 0 before the next edge, with no further start until a new frame has delivered pixel (4,4).
- Back-to-back frames (sof on the pixel after the last of the previous frame): 32 starts total, 2 frame_done pulses, and frame-2 windows contain no frame-1 pixels.
